// File: rtl/lockin_pkg.sv
// rtl/lockin_pkg.sv - shared record layout, header/trailer magics and state encoding
package lockin_pkg;

  localparam int REC_WIDTH    = 108;
  localparam int REC_X_LSB    = 0;
  localparam int REC_X_W      = 32;
  localparam int REC_Y_LSB    = 32;
  localparam int REC_Y_W      = 32;
  localparam int REC_FREQ_LSB = 64;
  localparam int REC_FREQ_W   = 32;
  localparam int REC_ID_LSB   = 96;
  localparam int REC_ID_W     = 8;

  localparam logic [15:0] HDR_MAGIC_DEFAULT = 16'hA5C3;
  localparam logic [15:0] TRL_MAGIC_DEFAULT = 16'h5A3C;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_HEADER  = 3'd1;
  localparam logic [2:0] ST_TSTAMP  = 3'd2;
  localparam logic [2:0] ST_FETCH   = 3'd3;
  localparam logic [2:0] ST_LATCH   = 3'd4;
  localparam logic [2:0] ST_WORDS   = 3'd5;
  localparam logic [2:0] ST_TRAILER = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_HEADER  = ST_HEADER,
    S_TSTAMP  = ST_TSTAMP,
    S_FETCH   = ST_FETCH,
    S_LATCH   = ST_LATCH,
    S_WORDS   = ST_WORDS,
    S_TRAILER = ST_TRAILER
  } state_t;

  typedef struct packed {
    logic [REC_ID_W-1:0]   id;
    logic [REC_FREQ_W-1:0] freq;
    logic [REC_Y_W-1:0]    y;
    logic [REC_X_W-1:0]    x;
  } record_t;

  function automatic record_t unpack_record(input logic [REC_WIDTH-1:0] q);
    record_t r;
    r.id   = q[REC_ID_LSB +: REC_ID_W];
    r.freq = q[REC_FREQ_LSB +: REC_FREQ_W];
    r.y    = q[REC_Y_LSB +: REC_Y_W];
    r.x    = q[REC_X_LSB +: REC_X_W];
    return r;
  endfunction

endpackage

// File: rtl/tx_word_holder.sv
// rtl/tx_word_holder.sv - single-entry output register with valid/ready hold semantics
module tx_word_holder (
  input  logic        clk_udp,
  input  logic        reset,
  input  logic [31:0] in_data,
  input  logic        in_sop,
  input  logic        in_eop,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] tx_data,
  output logic        tx_valid,
  output logic        tx_sop,
  output logic        tx_eop,
  input  logic        tx_ready
);

  // Refill in the same cycle the held word drains so WORDS runs at one word per clock.
  assign in_ready = !tx_valid || tx_ready;

  always_ff @(posedge clk_udp or posedge reset) begin
    if (reset) begin
      tx_data  <= '0;
      tx_valid <= 1'b0;
      tx_sop   <= 1'b0;
      tx_eop   <= 1'b0;
    end else if (in_valid && in_ready) begin
      tx_data  <= in_data;
      tx_valid <= 1'b1;
      tx_sop   <= in_sop;
      tx_eop   <= in_eop;
    end else if (tx_ready) begin
      tx_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/lockin_udp_packetizer.sv
// rtl/lockin_udp_packetizer.sv - frames lock-in FIFO records into UDP payload packets
// Optional PACKETIZER_TIMESTAMP_EN adds a cycle-count word after the header.
module lockin_udp_packetizer
  import lockin_pkg::*;
#(
  parameter int          RECORDS_PER_PACKET = 32,
  parameter int          TIMEOUT_CYCLES     = 1250,
  parameter logic [15:0] HDR_MAGIC          = HDR_MAGIC_DEFAULT,
  parameter logic [15:0] TRL_MAGIC          = TRL_MAGIC_DEFAULT
) (
  input  logic                 clk_udp,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [REC_WIDTH-1:0] fifo_q,
  input  logic                 fifo_rdempty,
  output logic                 fifo_rdreq,
  output logic [31:0]          tx_data,
  output logic                 tx_valid,
  output logic                 tx_sop,
  output logic                 tx_eop,
  input  logic                 tx_ready,
  output logic [15:0]          packet_count
);

  localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]    RPP      = 8'(RECORDS_PER_PACKET);

  state_t        state, state_n;
  record_t       rec;
  logic [7:0]    nrec;
  logic [1:0]    widx;
  logic [TW-1:0] tmo_cnt;
  logic [15:0]   seq;

  logic [31:0]   push_data;
  logic          push_valid, push_sop, push_eop, in_ready;
  logic          word_taken;
  logic          tmo_armed;
  logic          unused_fifo_bits;

  assign unused_fifo_bits = ^fifo_q[REC_WIDTH-1:REC_ID_LSB+REC_ID_W];
  assign word_taken       = push_valid && in_ready;
  // Only an open packet (at least one record sent) may time out.
  assign tmo_armed        = (state == S_FETCH) && fifo_rdempty && (nrec != 8'd0);

`ifdef PACKETIZER_TIMESTAMP_EN
  logic [31:0] cycle_cnt;
  logic [31:0] ts_word;

  always_ff @(posedge clk_udp or posedge reset) begin
    if (reset) begin
      cycle_cnt <= '0;
      ts_word   <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (state == S_HEADER && in_ready) ts_word <= cycle_cnt;
    end
  end
`endif

  always_comb begin
    state_n    = state;
    push_valid = 1'b0;
    push_data  = '0;
    push_sop   = 1'b0;
    push_eop   = 1'b0;
    fifo_rdreq = 1'b0;
    case (state)
      S_IDLE: begin
        if (enable && !fifo_rdempty) state_n = S_HEADER;
      end
      S_HEADER: begin
        push_valid = 1'b1;
        push_sop   = 1'b1;
        push_data  = {HDR_MAGIC, seq};
`ifdef PACKETIZER_TIMESTAMP_EN
        if (in_ready) state_n = S_TSTAMP;
`else
        if (in_ready) state_n = S_FETCH;
`endif
      end
`ifdef PACKETIZER_TIMESTAMP_EN
      S_TSTAMP: begin
        push_valid = 1'b1;
        push_data  = ts_word;
        if (in_ready) state_n = S_FETCH;
      end
`endif
      S_FETCH: begin
        if (!fifo_rdempty) begin
          fifo_rdreq = 1'b1;
          state_n    = S_LATCH;
        end else if (tmo_armed && tmo_cnt == TMO_LAST) begin
          state_n = S_TRAILER;
        end
      end
      S_LATCH: begin
        state_n = S_WORDS;
      end
      S_WORDS: begin
        push_valid = 1'b1;
        case (widx)
          2'd0:    push_data = {24'd0, rec.id};
          2'd1:    push_data = rec.freq;
          2'd2:    push_data = rec.y;
          default: push_data = rec.x;
        endcase
        if (in_ready && widx == 2'd3)
          state_n = ((nrec + 8'd1) == RPP) ? S_TRAILER : S_FETCH;
      end
      S_TRAILER: begin
        push_valid = 1'b1;
        push_eop   = 1'b1;
        push_data  = {TRL_MAGIC, 8'd0, nrec};
        if (in_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_udp or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      rec          <= '0;
      nrec         <= '0;
      widx         <= '0;
      tmo_cnt      <= '0;
      seq          <= '0;
      packet_count <= '0;
    end else begin
      state <= state_n;
      if (state == S_LATCH) begin
        rec     <= unpack_record(fifo_q);
        tmo_cnt <= '0;
        widx    <= '0;
      end
      if (tmo_armed && tmo_cnt != TMO_MAX) tmo_cnt <= tmo_cnt + TW'(1);
      if (state == S_WORDS && word_taken) begin
        widx <= widx + 2'd1;
        if (widx == 2'd3) nrec <= nrec + 8'd1;
      end
      if (state == S_TRAILER && word_taken) begin
        seq     <= seq + 16'd1;
        nrec    <= '0;
        tmo_cnt <= '0;
      end
      // Counted when the trailer leaves the output register, i.e. the packet is fully sent.
      if (tx_valid && tx_ready && tx_eop) packet_count <= packet_count + 16'd1;
    end
  end

  tx_word_holder u_holder (
    .clk_udp  (clk_udp),
    .reset    (reset),
    .in_data  (push_data),
    .in_sop   (push_sop),
    .in_eop   (push_eop),
    .in_valid (push_valid),
    .in_ready (in_ready),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_sop   (tx_sop),
    .tx_eop   (tx_eop),
    .tx_ready (tx_ready)
  );

endmodule
